// File: rtl/lsu_axi_gpio_bridge.sv
// AXI4 write-only slave that lets the core LSU drive a 32-bit GPIO output/enable pair.
// One outstanding burst; only single-beat writes to the page base are applied.

module lsu_axi_gpio_lane #(
  parameter logic [7:0] OUT_RST = 8'h00,
  parameter logic [7:0] OEB_RST = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic       i_se_out,
  input  logic       i_se_oeb,
  input  logic [7:0] i_d_out,
  input  logic [7:0] i_d_oeb,
  output logic [7:0] o_out,
  output logic [7:0] o_oeb
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out <= OUT_RST;
      o_oeb <= OEB_RST;
    end else if (i_we) begin
      if (i_se_out) o_out <= i_d_out;
      if (i_se_oeb) o_oeb <= i_d_oeb;
    end
  end
endmodule

module lsu_axi_gpio_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'hD000_0000,
  parameter logic [31:0] OUT_RST   = 32'h0000_0000,
  parameter logic [31:0] OEB_RST   = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        awvalid,
  output logic        awready,
  input  logic [2:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [2:0]  bid,
  output logic [1:0]  bresp,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_oeb,
  output logic        wr_pulse
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_id;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic        r_err;

  logic        w_dec_ok;
  logic        w_beat;
  logic        w_last_beat;
  logic        w_wr;
  logic [NUM_LANES-1:0][7:0] w_out;
  logic [NUM_LANES-1:0][7:0] w_oeb;

  // Only a single beat to the first doubleword of the page is a legal register write.
  assign w_dec_ok    = ((awaddr & 32'hFFFF_F000) == (BASE_ADDR & 32'hFFFF_F000)) &&
                       ((awaddr & 32'h0000_0FF8) == 32'h0) && (awlen == 8'd0);
  assign w_beat      = wvalid & wready;
  assign w_last_beat = w_beat && (r_cnt == r_len);
  assign w_wr        = w_last_beat && !r_err && wlast;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lsu_axi_gpio_lane #(
      .OUT_RST(OUT_RST[8*k +: 8]),
      .OEB_RST(OEB_RST[8*k +: 8])
    ) u_lane (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_we    (w_wr),
      .i_se_out(wstrb[k]),
      .i_se_oeb(wstrb[k+NUM_LANES]),
      .i_d_out (wdata[8*k +: 8]),
      .i_d_oeb (wdata[32 + 8*k +: 8]),
      .o_out   (w_out[k]),
      .o_oeb   (w_oeb[k])
    );
  end

  assign gpio_out = w_out;
  assign gpio_oeb = w_oeb;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= 3'd0;
      bresp    <= 2'b00;
      wr_pulse <= 1'b0;
      r_id     <= 3'd0;
      r_len    <= 8'd0;
      r_cnt    <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      wr_pulse <= w_wr && (wstrb != 8'h00);
      case (r_state)
        S_IDLE: if (awvalid) begin
          r_id    <= awid;
          r_len   <= awlen;
          r_cnt   <= 8'd0;
          r_err   <= !w_dec_ok;
          awready <= 1'b0;
          wready  <= 1'b1;
          r_state <= S_DATA;
        end
        S_DATA: if (w_last_beat) begin
          wready  <= 1'b0;
          bvalid  <= 1'b1;
          bid     <= r_id;
          bresp   <= (r_err || !wlast) ? 2'b10 : 2'b00;
          r_state <= S_RESP;
        end else if (w_beat) begin
          // Burst length comes from awlen alone; an early wlast only taints the response.
          r_cnt <= r_cnt + 8'd1;
          if (wlast) r_err <= 1'b1;
        end
        S_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          awready <= 1'b1;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_axi_gpio_bridge.sv
// Directed bench for lsu_axi_gpio_bridge: handshake timing, byte-lane writes, error paths, reset.

module tb_lsu_axi_gpio_bridge;
  localparam logic [31:0] BASE = 32'hD000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [2:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [2:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] gpio_out, gpio_oeb;
  logic        wr_pulse;

  int n_cmp = 0;
  int n_mis = 0;
  int pulse_cnt = 0;
  int hs_cnt = 0;
  int bv_cnt = 0;

  lsu_axi_gpio_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  // Inputs only move 1 time unit after a rising edge, so the falling edge sees settled values.
  always @(negedge clk) begin
    if (wr_pulse) pulse_cnt++;
    if (wvalid && wready) hs_cnt++;
    if (bvalid) bv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [63:0] data, input logic [7:0] strb, input int last_at,
                      input int bdly, output logic [1:0] resp, output logic [2:0] rid);
    int n;
    int b;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    n = 0;
    while (!awready && n < 100) begin step(); n++; end
    chk("aw_wait", n < 100, 1'b1);
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = data; wstrb = strb;
    b = 0; n = 0;
    while (b <= int'(len) && n < 2000) begin
      wlast = (b == last_at);
      if (wready) b++;
      step();
      n++;
    end
    chk("w_wait", n < 2000, 1'b1);
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 100) begin step(); n++; end
    chk("b_wait", n < 100, 1'b1);
    resp = bresp; rid = bid;
    for (int i = 0; i < bdly; i++) begin
      step();
      chk("hold_bvalid", bvalid, 1'b1);
      chk("hold_bresp", bresp, resp);
      chk("hold_bid", bid, rid);
      chk("hold_awready", awready, 1'b0);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("awready_after_b", awready, 1'b1);
    chk("bvalid_after_b", bvalid, 1'b0);
  endtask

  logic [1:0] r;
  logic [2:0] id;
  int p0, h0, bv0;

  initial begin
    rst = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bid", bid, 3'd0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_out", gpio_out, 32'h0000_0000);
    chk("rst_oeb", gpio_oeb, 32'hFFFF_FFFF);
    chk("rst_pulse", wr_pulse, 1'b0);

    // Minimum-latency single write, W presented together with AW
    p0 = pulse_cnt;
    awvalid = 1; awid = 3'd5; awaddr = BASE; awlen = 8'd0;
    wvalid = 1; wdata = 64'h0000_00F0_1234_5678; wstrb = 8'h1F; wlast = 1; bready = 1;
    chk("idle_wready", wready, 1'b0);
    step();
    awvalid = 0;
    chk("n1_wready", wready, 1'b1);
    chk("n1_awready", awready, 1'b0);
    chk("n1_bvalid", bvalid, 1'b0);
    step();
    wvalid = 0; wlast = 0;
    chk("n2_bvalid", bvalid, 1'b1);
    chk("n2_bid", bid, 3'd5);
    chk("n2_bresp", bresp, 2'b00);
    chk("n2_out", gpio_out, 32'h1234_5678);
    chk("n2_oeb", gpio_oeb, 32'hFFFF_FFF0);
    chk("n2_pulse", wr_pulse, 1'b1);
    chk("n2_wready", wready, 1'b0);
    step();
    bready = 0;
    chk("n3_awready", awready, 1'b1);
    chk("n3_bvalid", bvalid, 1'b0);
    chk("n3_pulse", wr_pulse, 1'b0);
    chk("t1_pulses", pulse_cnt - p0, 1);

    // Single-byte update
    p0 = pulse_cnt;
    xact(3'd1, BASE, 8'd0, 64'h0000_0000_0000_AB00, 8'h02, 0, 0, r, id);
    chk("t2_resp", r, 2'b00);
    chk("t2_bid", id, 3'd1);
    chk("t2_out", gpio_out, 32'h1234_AB78);
    chk("t2_oeb", gpio_oeb, 32'hFFFF_FFF0);
    chk("t2_pulses", pulse_cnt - p0, 1);

    // Address outside the register doubleword
    p0 = pulse_cnt; h0 = hs_cnt;
    xact(3'd2, BASE + 32'd8, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, r, id);
    chk("t3_resp", r, 2'b10);
    chk("t3_bid", id, 3'd2);
    chk("t3_beats", hs_cnt - h0, 1);
    chk("t3_out", gpio_out, 32'h1234_AB78);
    chk("t3_oeb", gpio_oeb, 32'hFFFF_FFF0);
    chk("t3_pulses", pulse_cnt - p0, 0);

    // Wrong page
    p0 = pulse_cnt;
    xact(3'd3, BASE + 32'h1000, 8'd0, 64'h0, 8'hFF, 0, 0, r, id);
    chk("t4_resp", r, 2'b10);
    chk("t4_out", gpio_out, 32'h1234_AB78);
    chk("t4_pulses", pulse_cnt - p0, 0);

    // Four-beat burst: all beats accepted, no write
    p0 = pulse_cnt; h0 = hs_cnt;
    xact(3'd4, BASE, 8'd3, 64'h0, 8'hFF, 3, 0, r, id);
    chk("t5_resp", r, 2'b10);
    chk("t5_beats", hs_cnt - h0, 4);
    chk("t5_out", gpio_out, 32'h1234_AB78);
    chk("t5_oeb", gpio_oeb, 32'hFFFF_FFF0);
    chk("t5_pulses", pulse_cnt - p0, 0);

    // Single beat without wlast
    p0 = pulse_cnt;
    xact(3'd6, BASE, 8'd0, 64'h0, 8'hFF, -1, 0, r, id);
    chk("t6_resp", r, 2'b10);
    chk("t6_out", gpio_out, 32'h1234_AB78);
    chk("t6_pulses", pulse_cnt - p0, 0);

    // Early wlast does not shorten the burst
    h0 = hs_cnt;
    xact(3'd7, BASE, 8'd1, 64'h0, 8'hFF, 0, 0, r, id);
    chk("t7_resp", r, 2'b10);
    chk("t7_beats", hs_cnt - h0, 2);

    // Low address bits inside the doubleword are fine; zero strobe: OKAY, no pulse; bready held off
    p0 = pulse_cnt;
    xact(3'd3, BASE + 32'd4, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 5, r, id);
    chk("t8_resp", r, 2'b00);
    chk("t8_bid", id, 3'd3);
    chk("t8_out", gpio_out, 32'h1234_AB78);
    chk("t8_pulses", pulse_cnt - p0, 0);

    // Upper strobes only: enable all pads
    xact(3'd0, BASE, 8'd0, 64'h0000_0000_FFFF_FFFF, 8'hF0, 0, 0, r, id);
    chk("t9_resp", r, 2'b00);
    chk("t9_out", gpio_out, 32'h1234_AB78);
    chk("t9_oeb", gpio_oeb, 32'h0000_0000);

    // Maximum burst length
    h0 = hs_cnt;
    xact(3'd5, BASE, 8'd255, 64'h0, 8'hFF, 255, 0, r, id);
    chk("t10_resp", r, 2'b10);
    chk("t10_beats", hs_cnt - h0, 256);
    chk("t10_oeb", gpio_oeb, 32'h0000_0000);

    // Reset while in DATA
    awvalid = 1; awid = 3'd2; awaddr = BASE; awlen = 8'd0;
    step();
    awvalid = 0;
    chk("t11_in_data", wready, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("t11_async_awready", awready, 1'b1);
    chk("t11_async_wready", wready, 1'b0);
    chk("t11_out", gpio_out, 32'h0000_0000);
    chk("t11_oeb", gpio_oeb, 32'hFFFF_FFFF);
    step();
    step();
    rst = 1'b0;
    bv0 = bv_cnt; p0 = pulse_cnt;
    wvalid = 1; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF; wlast = 1;
    chk("t11_idle_wready", wready, 1'b0);
    repeat (5) step();
    wvalid = 0; wlast = 0;
    chk("t11_no_b", bv_cnt - bv0, 0);
    chk("t11_no_pulse", pulse_cnt - p0, 0);
    chk("t11_out_hold", gpio_out, 32'h0000_0000);
    chk("t11_oeb_hold", gpio_oeb, 32'hFFFF_FFFF);

    p0 = pulse_cnt;
    xact(3'd6, BASE, 8'd0, 64'hA5A5_0000_DEAD_BEEF, 8'hFF, 0, 0, r, id);
    chk("t12_resp", r, 2'b00);
    chk("t12_bid", id, 3'd6);
    chk("t12_out", gpio_out, 32'hDEAD_BEEF);
    chk("t12_oeb", gpio_oeb, 32'hA5A5_0000);
    chk("t12_pulses", pulse_cnt - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
